// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared types and default parameters for the branch target
//            predictor: 2-bit saturating counter encoding, default BTB entry
//            layout and default widths.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package bp_pkg;

  localparam int BP_PC_WIDTH     = 24;
  localparam int BP_TARGET_WIDTH = 16;
  localparam int BP_INDEX_BITS   = 4;
  localparam int BP_TAG_BITS     = 8;
  localparam int BP_COUNT_WIDTH  = 16;

  // Direction counter; the MSB alone decides "predict taken".
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  // Entry layout at the default widths. The top module declares the same
  // layout locally so that it follows its own parameter values.
  typedef struct packed {
    logic                       valid;
    logic [BP_TAG_BITS-1:0]     tag;
    logic [BP_PC_WIDTH-1:0]     target;
    bp_ctr_t                    ctr;
  } bp_entry_t;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module   : bp_sat_counter2
// Purpose  : Combinational next-state for a 2-bit saturating direction
//            counter (SNT <-> WNT <-> WT <-> ST).
// Ports    : ctr_i   [1:0] current counter value
//            taken_i       resolved direction (1 = count up)
//            ctr_o   [1:0] next counter value
// Revision : 1.0  initial release
// ============================================================================
module bp_sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule : bp_sat_counter2
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_predictor
// Purpose  : Direct-mapped BTB with a 2-bit saturating counter per entry.
//            Zero-latency lookup of the next fetch PC; trained by one
//            resolved branch/jump per cycle. Optional statistics counters
//            are built when the macro BP_PERF_COUNT_EN is defined.
// Ports    : Clk, Reset (sync, active-high)
//            PC                 fetch PC             -> Prediction, PredTaken
//            UpdateValid/UpdatePC/UpdateTaken/ActualBranchTarget  training
//            Correct            statistics only
//            UpdateCount, MispredictCount   (BP_PERF_COUNT_EN only)
// Revision : 1.0  initial release
// ============================================================================
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH     = BP_PC_WIDTH,
  parameter int TARGET_WIDTH = BP_TARGET_WIDTH,
  parameter int INDEX_BITS   = BP_INDEX_BITS,
  parameter int TAG_BITS     = BP_TAG_BITS,
  parameter int COUNT_WIDTH  = BP_COUNT_WIDTH
)(
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [PC_WIDTH-1:0]     PC,
  output logic [PC_WIDTH-1:0]     Prediction,
  output logic                    PredTaken,
  input  logic                    UpdateValid,
  input  logic [PC_WIDTH-1:0]     UpdatePC,
  input  logic                    UpdateTaken,
  input  logic [TARGET_WIDTH-1:0] ActualBranchTarget,
  input  logic                    Correct
`ifdef BP_PERF_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]  UpdateCount,
  output logic [COUNT_WIDTH-1:0]  MispredictCount
`endif
);

  localparam int c_ENTRIES = 1 << INDEX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [PC_WIDTH-1:0] target;
    logic [1:0]          ctr;
  } entry_t;

  entry_t btb_q [c_ENTRIES];

  // ---------------- lookup (reads pre-update state, no bypass) -------------
  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  entry_t                w_lk_entry;
  logic                  w_lk_hit;

  assign w_lk_idx   = PC[INDEX_BITS-1:0];
  assign w_lk_tag   = PC[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign w_lk_entry = btb_q[w_lk_idx];
  assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
  assign PredTaken  = w_lk_hit && w_lk_entry.ctr[1];
  assign Prediction = PredTaken ? w_lk_entry.target : PC + 1'b1;

  // ---------------- update -----------------------------------------------
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0]   w_up_tag;
  entry_t                w_up_entry;
  logic                  w_up_hit;
  logic [1:0]            w_up_ctr_next;
  logic [PC_WIDTH-1:0]   w_up_target;
  logic                  w_up_we;
  entry_t                w_up_new;

  assign w_up_idx    = UpdatePC[INDEX_BITS-1:0];
  assign w_up_tag    = UpdatePC[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign w_up_entry  = btb_q[w_up_idx];
  assign w_up_hit    = w_up_entry.valid && (w_up_entry.tag == w_up_tag);
  assign w_up_target = PC_WIDTH'(ActualBranchTarget);

  bp_sat_counter2 u_ctr (
    .ctr_i   (w_up_entry.ctr),
    .taken_i (UpdateTaken),
    .ctr_o   (w_up_ctr_next)
  );

  // A not-taken miss leaves the table alone; every other case writes.
  assign w_up_we = UpdateValid && (w_up_hit || UpdateTaken);

  always_comb begin
    w_up_new        = w_up_entry;
    w_up_new.valid  = 1'b1;
    w_up_new.tag    = w_up_tag;
    if (w_up_hit) begin
      w_up_new.ctr = w_up_ctr_next;
      if (UpdateTaken) w_up_new.target = w_up_target;
    end else begin
      w_up_new.ctr    = WT;
      w_up_new.target = w_up_target;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < c_ENTRIES; i++) btb_q[i] <= '0;
    end else if (w_up_we) begin
      btb_q[w_up_idx] <= w_up_new;
    end
  end

  // ---------------- optional statistics ----------------------------------
`ifdef BP_PERF_COUNT_EN
  logic [COUNT_WIDTH-1:0] upd_cnt_q, mis_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else if (UpdateValid) begin
      if (upd_cnt_q != '1) upd_cnt_q <= upd_cnt_q + 1'b1;
      if (!Correct && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign UpdateCount     = upd_cnt_q;
  assign MispredictCount = mis_cnt_q;

  logic unused_ok;
  assign unused_ok = ^{UpdatePC};
`else
  logic unused_ok;
  assign unused_ok = ^{UpdatePC, Correct, 1'(COUNT_WIDTH)};
`endif

endmodule : branch_target_predictor
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_target_predictor
// Purpose  : Directed self-checking bench for branch_target_predictor.
//            Statistics checks are built when BP_PERF_COUNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_target_predictor;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [23:0] PC;
  logic [23:0] Prediction;
  logic        PredTaken;
  logic        UpdateValid;
  logic [23:0] UpdatePC;
  logic        UpdateTaken;
  logic [15:0] ActualBranchTarget;
  logic        Correct;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

`ifdef BP_PERF_COUNT_EN
  logic [15:0] UpdateCount, MispredictCount;
  logic [23:0] pred2;
  logic        pt2;
  logic [1:0]  upd2, mis2;
`endif

  branch_target_predictor dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .PC                 (PC),
    .Prediction         (Prediction),
    .PredTaken          (PredTaken),
    .UpdateValid        (UpdateValid),
    .UpdatePC           (UpdatePC),
    .UpdateTaken        (UpdateTaken),
    .ActualBranchTarget (ActualBranchTarget),
    .Correct            (Correct)
`ifdef BP_PERF_COUNT_EN
    ,
    .UpdateCount        (UpdateCount),
    .MispredictCount    (MispredictCount)
`endif
  );

`ifdef BP_PERF_COUNT_EN
  branch_target_predictor #(.COUNT_WIDTH(2)) dut_sat (
    .Clk                (Clk),
    .Reset              (Reset),
    .PC                 (PC),
    .Prediction         (pred2),
    .PredTaken          (pt2),
    .UpdateValid        (UpdateValid),
    .UpdatePC           (UpdatePC),
    .UpdateTaken        (UpdateTaken),
    .ActualBranchTarget (ActualBranchTarget),
    .Correct            (Correct),
    .UpdateCount        (upd2),
    .MispredictCount    (mis2)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [23:0] pc,
                      input logic [23:0] exp_pred, input logic exp_taken);
    PC = pc;
    #1;
    check_eq({tag, ".pred"}, 32'(Prediction), 32'(exp_pred));
    check_eq({tag, ".taken"}, 32'(PredTaken), 32'(exp_taken));
  endtask

  task automatic update(input logic [23:0] pc, input logic taken,
                        input logic [15:0] tgt, input logic correct);
    UpdateValid        = 1'b1;
    UpdatePC           = pc;
    UpdateTaken        = taken;
    ActualBranchTarget = tgt;
    Correct            = correct;
    tick();
    UpdateValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; PC = 24'h000010; UpdateValid = 1'b0; UpdatePC = '0;
    UpdateTaken = 1'b0; ActualBranchTarget = '0; Correct = 1'b1;
    #1;
    tick();
    // Reset state
    look("rst_pc10",  24'h000010, 24'h000011, 1'b0);
    look("rst_wrap",  24'hFFFFFF, 24'h000000, 1'b0);
    Reset = 1'b0;
    tick();

    // Allocation: same-cycle lookup still sees the empty entry
    UpdateValid = 1'b1; UpdatePC = 24'h000025; UpdateTaken = 1'b1;
    ActualBranchTarget = 16'h0040;
    look("alloc_same_cycle", 24'h000025, 24'h000026, 1'b0);
    tick();
    UpdateValid = 1'b0;
    look("alloc", 24'h000025, 24'h000040, 1'b1);

    // Hysteresis, target overwrite on taken hit, kept on not-taken hit
    update(24'h000025, 1'b0, 16'h0000, 1'b0);   // WT -> WNT
    look("wnt", 24'h000025, 24'h000026, 1'b0);
    update(24'h000025, 1'b1, 16'h0044, 1'b0);   // WNT -> WT, new target
    look("wt_newtgt", 24'h000025, 24'h000044, 1'b1);
    update(24'h000025, 1'b1, 16'h0044, 1'b1);   // WT -> ST
    update(24'h000025, 1'b0, 16'h0099, 1'b0);   // ST -> WT, target kept
    look("st_to_wt", 24'h000025, 24'h000044, 1'b1);

    // Tag conflict at index 5: old target visible during the update cycle
    UpdateValid = 1'b1; UpdatePC = 24'h000135; UpdateTaken = 1'b1;
    ActualBranchTarget = 16'h0080;
    look("conflict_same_cycle", 24'h000025, 24'h000044, 1'b1);
    tick();
    UpdateValid = 1'b0;
    look("conflict_evicted", 24'h000025, 24'h000026, 1'b0);
    look("conflict_new",     24'h000135, 24'h000080, 1'b1);

    // Not-taken miss allocates nothing
    update(24'h000037, 1'b0, 16'h0123, 1'b1);
    look("nt_miss", 24'h000037, 24'h000038, 1'b0);

    // Saturation at SNT: three down from WT, one up lands in WNT
    update(24'h000135, 1'b0, 16'h0000, 1'b1);
    update(24'h000135, 1'b0, 16'h0000, 1'b1);
    update(24'h000135, 1'b0, 16'h0000, 1'b1);
    update(24'h000135, 1'b1, 16'h0080, 1'b1);
    look("snt_sat", 24'h000135, 24'h000136, 1'b0);

    // Independent indices, full-width target, upper-bit aliasing
    update(24'h000003, 1'b1, 16'h1234, 1'b1);
    update(24'h00000A, 1'b1, 16'hFFFF, 1'b1);
    look("idx3",   24'h000003, 24'h001234, 1'b1);
    look("idxA",   24'h00000A, 24'h00FFFF, 1'b1);
    look("alias",  24'h100003, 24'h001234, 1'b1);

    // Reset priority over a simultaneous taken update
    Reset = 1'b1;
    update(24'h000050, 1'b1, 16'h0090, 1'b1);
    Reset = 1'b0;
    look("rstpri_new", 24'h000050, 24'h000051, 1'b0);
    look("rstpri_old", 24'h000003, 24'h000004, 1'b0);

`ifdef BP_PERF_COUNT_EN
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_eq("cnt_rst_upd", 32'(UpdateCount), 32'd0);
    check_eq("cnt_rst_mis", 32'(MispredictCount), 32'd0);
    update(24'h000001, 1'b1, 16'h0010, 1'b1);
    update(24'h000002, 1'b0, 16'h0000, 1'b0);
    update(24'h000001, 1'b1, 16'h0010, 1'b1);
    update(24'h000003, 1'b1, 16'h0020, 1'b0);
    update(24'h000002, 1'b0, 16'h0000, 1'b1);
    check_eq("cnt_upd", 32'(UpdateCount), 32'd5);
    check_eq("cnt_mis", 32'(MispredictCount), 32'd2);
    check_eq("cnt_sat_upd", 32'(upd2), 32'd3);
    check_eq("cnt_sat_mis", 32'(mis2), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_branch_target_predictor
`default_nettype wire

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch predictor for the fetch stage: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry. It replaces the always-not-taken predictor and keeps the same lookup contract: given the fetch `PC`, it returns the next fetch address. The table is trained every cycle in which the execute stage resolves a branch or jump.

## Interface
- `PC_WIDTH`, 24: fetch PC width.
- `TARGET_WIDTH`, 16: resolved target width; must be ≤ `PC_WIDTH`.
- `INDEX_BITS`, 4: log2 of BTB entries (16 entries).
- `TAG_BITS`, 8: stored tag width; `INDEX_BITS + TAG_BITS` ≤ `PC_WIDTH`.
- `COUNT_WIDTH`, 16: width of the statistics counters (present only with `BP_PERF_COUNT_EN`).

Ports:
- `Clk` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `PC` in `PC_WIDTH`: current fetch PC.
- `Prediction` out `PC_WIDTH`: predicted next fetch PC; combinational from `PC` and table state.
- `PredTaken` out 1: 1 when `Prediction` comes from the BTB target.
- `UpdateValid` in 1: a branch or jump resolved this cycle.
- `UpdatePC` in `PC_WIDTH`: PC of the resolved instruction.
- `UpdateTaken` in 1: actual direction.
- `ActualBranchTarget` in `TARGET_WIDTH`: actual target; zero-extended to `PC_WIDTH`.
- `Correct` in 1: the earlier prediction for this instruction matched. Used only for statistics.
- `UpdateCount` out `COUNT_WIDTH`: resolved-branch count (macro only).
- `MispredictCount` out `COUNT_WIDTH`: misprediction count (macro only).

## Operation
- **Indexing.** Index = `addr[INDEX_BITS-1:0]`; tag = `addr[INDEX_BITS+TAG_BITS-1:INDEX_BITS]`. The same fields are used for `PC` and `UpdatePC`. Aliasing of upper PC bits is accepted.
- **Entry contents.** `valid`, `tag`, `target` (`PC_WIDTH` bits), `ctr` (2 bits).
- **Counter states.** SNT=00, WNT=01, WT=10, ST=11.
- **Lookup.**
  - Hit = valid entry with matching tag.
  - On a hit with `ctr` ≥ WT: `Prediction` = `target` and `PredTaken` = 1.
  - Otherwise: `Prediction` = `PC + 1` (modulo 2^`PC_WIDTH`; all-ones wraps to 0) and `PredTaken` = 0.
- **Update** (when `UpdateValid` = 1):
  - Hit, taken: `ctr` increments, saturating at ST; `target` is overwritten with the new target.
  - Hit, not taken: `ctr` decrements, saturating at SNT; `target` is unchanged.
  - Miss, taken: the entry is allocated (replacing any occupant) with `valid` = 1, the new tag, the new target, and `ctr` = WT.
  - Miss, not taken: no change.
- **Same cycle, same index for lookup and update.** The lookup sees the pre-update state; there is no bypass. The new state is visible from the next cycle.
- **Reset.**
  - All `valid` bits, `ctr` values and `target` values clear to 0 in one cycle.
  - `Prediction` = `PC + 1` and `PredTaken` = 0 until the first taken update.
  - `Reset` has priority over `UpdateValid` in the same cycle. An update presented during reset is discarded.

## Timing
- Lookup has zero latency: `Prediction` is combinational within the fetch cycle.
- An update is written at the rising edge that samples `UpdateValid` and takes effect on lookups from the next cycle.
- One update per cycle; back-to-back updates to the same index apply in order.
- There is no handshake: `UpdateValid` is a single-cycle strobe and is never stalled.

## Configuration
- `BP_PERF_COUNT_EN` **defined:**
  - `UpdateCount` increments on every `UpdateValid`.
  - `MispredictCount` increments on `UpdateValid && !Correct`.
  - Both saturate at all-ones and reset to 0.
- `BP_PERF_COUNT_EN` **undefined:**
  - Both ports and both counters are absent.
  - `Correct` is unused.
  - Prediction behaviour is identical in both builds.

## Structure
- **Shared package `bp_pkg`:**
  - `bp_ctr_t` enum (SNT/WNT/WT/ST).
  - The BTB entry struct typedef.
  - Default parameter constants.
- **Sub-module `bp_sat_counter2`:** combinational next-state logic for the 2-bit saturating counter (inputs `ctr`, `taken`; output next `ctr`). The table register array lives in the top module.

## Test plan
- **Reset behaviour:** assert `Reset` with `PC` = 0x000010 → `Prediction` = 0x000011, `PredTaken` = 0. With `PC` = 0xFFFFFF → `Prediction` = 0x000000.
- **Allocate on taken miss:** update `UpdatePC` = 0x000025, taken, target 0x0040 → next cycle, `PC` = 0x000025 gives `Prediction` = 0x000040, `PredTaken` = 1.
- **Counter hysteresis:** from WT, one not-taken update → WNT, predicts `PC + 1`. Two taken updates → ST. One not-taken update → WT, still predicts the target.
- **Tag conflict:** allocate 0x000025, then taken update at 0x000135 (same index, different tag) → 0x000025 now predicts 0x000026. Same-cycle lookup of 0x000025 during that update still returns the old target.
- **Reset priority:** `Reset` and `UpdateValid` (taken) asserted together → no entry allocated; `PC + 1` predicted afterwards.
- **Statistics (`BP_PERF_COUNT_EN`):** 5 updates, 2 with `Correct` = 0 → `UpdateCount` = 5, `MispredictCount` = 2. With `COUNT_WIDTH` = 2, 5 updates → `UpdateCount` holds at 3.
